// File: rtl/axi_bridge_pkg.sv
// Shared AXI bridge types: burst encodings, AR entry layout, read-side FSM states.
// Optional AR protocol checking is enabled by defining AXI_AR_PROTOCOL_CHECK_EN.
package axi_bridge_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2,
      RSVD  = 2'd3
   } burst_t;

   typedef enum logic {
      RD_IDLE,
      RD_ACTIVE
   } rd_state_t;

   localparam logic [16:0] AXI_4KB = 17'd4096;

   typedef struct packed {
      logic [31:0] addr;
      burst_t      burst;
      logic [2:0]  size;
      logic [7:0]  len;
      logic [2:0]  prot;
`ifdef AXI_AR_PROTOCOL_CHECK_EN
      logic        err;
`endif
   } ar_entry_t;

`ifdef AXI_AR_PROTOCOL_CHECK_EN
   // Only the in-page offset matters for the 4KB crossing test.
   function automatic logic ar_protocol_err(input logic [11:0] addr_lo,
                                            input burst_t      burst,
                                            input logic [2:0]  size,
                                            input logic [7:0]  len);
      logic [16:0] bytes;
      logic [16:0] end_off;
      logic        err;
      bytes   = ({9'b0, len} + 17'd1) << size;
      end_off = {5'b0, addr_lo} + bytes;
      err     = 1'b0;
      case (burst)
         RSVD: err = 1'b1;
         WRAP: err = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
         INCR: err = (end_off > AXI_4KB);
         default: err = 1'b0;
      endcase
      return err;
   endfunction
`endif

endpackage

// File: rtl/axi_ar_capture_fifo_if.sv
// AR channel plus head-entry presentation bundle for the AR capture FIFO.
interface axi_ar_capture_fifo_if #(
   parameter int unsigned PTR_W = 4
);
   logic [31:0]      ARADDR;
   logic [1:0]       ARBURST;
   logic [2:0]       ARSIZE;
   logic [7:0]       ARLEN;
   logic [2:0]       ARPROT;
   logic             ARVALID;
   logic             ARREADY;
   logic             burst_done;
   logic [31:0]      POPPED_ADDRESS_SA;
   logic [1:0]       ARBURST_FIFO;
   logic [2:0]       ARSIZE_FIFO;
   logic [7:0]       ARLEN_FIFO;
   logic [2:0]       R_Prot_FIFO;
   logic [PTR_W-1:0] rd_ptr_address;
   logic             head_active;
   logic [PTR_W:0]   fifo_count;
   logic             head_err;

   modport slave (
      input  ARADDR, ARBURST, ARSIZE, ARLEN, ARPROT, ARVALID, burst_done,
      output ARREADY, POPPED_ADDRESS_SA, ARBURST_FIFO, ARSIZE_FIFO, ARLEN_FIFO,
             R_Prot_FIFO, rd_ptr_address, head_active, fifo_count, head_err
   );

   modport master (
      output ARADDR, ARBURST, ARSIZE, ARLEN, ARPROT, ARVALID, burst_done,
      input  ARREADY, POPPED_ADDRESS_SA, ARBURST_FIFO, ARSIZE_FIFO, ARLEN_FIFO,
             R_Prot_FIFO, rd_ptr_address, head_active, fifo_count, head_err
   );
endinterface

// File: rtl/axi_ar_fifo_mem.sv
// Circular-buffer storage: one synchronous write port, one asynchronous read port, no reset.
module axi_ar_fifo_mem #(
   parameter int unsigned PTR_W   = 4,
   parameter int unsigned ENTRY_W = 48
) (
   input  logic               clk,
   input  logic               we,
   input  logic [PTR_W-1:0]   waddr,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic [PTR_W-1:0]   raddr,
   output logic [ENTRY_W-1:0] rdata
);
   logic [ENTRY_W-1:0] mem [2**PTR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/axi_ar_capture_fifo.sv
// AXI AR capture stage: buffers AR handshakes and presents one registered head burst at a time.
// Define AXI_AR_PROTOCOL_CHECK_EN to store and present a per-entry protocol error bit.
module axi_ar_capture_fifo
   import axi_bridge_pkg::*;
#(
   parameter int unsigned PTR_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   axi_ar_capture_fifo_if.slave ar
);
   localparam int unsigned      ENTRY_W = $bits(ar_entry_t);
   localparam logic [PTR_W:0]   DEPTH   = {1'b1, {PTR_W{1'b0}}};
   localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

   rd_state_t          state, state_n;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [PTR_W:0]     count;
   ar_entry_t          head;
   ar_entry_t          wr_entry;
   logic [ENTRY_W-1:0] mem_rdata;
   logic               full, empty, wr_en, load;

   // Status comes from the registered count only, keeping ARREADY off the ARVALID path.
   assign full  = (count == DEPTH);
   assign empty = (count == '0);
   assign wr_en = ar.ARVALID && !full;

   always_comb begin
      wr_entry       = '0;
      wr_entry.addr  = ar.ARADDR;
      wr_entry.burst = burst_t'(ar.ARBURST);
      wr_entry.size  = ar.ARSIZE;
      wr_entry.len   = ar.ARLEN;
      wr_entry.prot  = ar.ARPROT;
`ifdef AXI_AR_PROTOCOL_CHECK_EN
      wr_entry.err   = ar_protocol_err(ar.ARADDR[11:0], burst_t'(ar.ARBURST),
                                       ar.ARSIZE, ar.ARLEN);
`endif
   end

   axi_ar_fifo_mem #(
      .PTR_W   (PTR_W),
      .ENTRY_W (ENTRY_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RD_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      case (state)
         RD_IDLE: begin
            if (!empty) begin
               load    = 1'b1;
               state_n = RD_ACTIVE;
            end
         end
         RD_ACTIVE: begin
            if (ar.burst_done) begin
               if (!empty) begin
                  load = 1'b1;
               end else begin
                  state_n = RD_IDLE;
               end
            end
         end
         default: state_n = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (load) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            head   <= ar_entry_t'(mem_rdata);
         end
         case ({wr_en, load})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign ar.ARREADY           = !full;
   assign ar.POPPED_ADDRESS_SA = head.addr;
   assign ar.ARBURST_FIFO      = head.burst;
   assign ar.ARSIZE_FIFO       = head.size;
   assign ar.ARLEN_FIFO        = head.len;
   assign ar.R_Prot_FIFO       = head.prot;
   assign ar.rd_ptr_address    = rd_ptr;
   assign ar.head_active       = (state == RD_ACTIVE);
   assign ar.fifo_count        = count;
`ifdef AXI_AR_PROTOCOL_CHECK_EN
   assign ar.head_err          = head.err;
`else
   assign ar.head_err          = 1'b0;
`endif

endmodule
